sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO, successor to sync_fifo. Adds selectable standard/first-word-fall-through read mode, programmable almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow error flags. Used as the general buffering element between same-clock producer/consumer blocks.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
ADDR_WIDTH, 3, log2 depth; DEPTH = 2**ADDR_WIDTH (>=1)
FWFT, 0, 0 = standard read (registered data after rd_en), 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, wr_almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, rd_almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
wr_full  out  1  count == DEPTH
wr_almost_full  out  1  count >= AF_LEVEL
rd_en  in  1  read request
rd_data  out  DATA_WIDTH  read word
rd_empty  out  1  count == 0
rd_almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted and rejected
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at clk edge): pointers=0, count=0, rd_empty=1, wr_full=0, wr_almost_full=(AF_LEVEL==0 ? 1 : 0), rd_almost_empty=1, overflow=0, underflow=0, rd_data=0 (standard mode). Storage contents not reset. Reset mid-operation discards all data; reset has priority over every other input.
- All flags and count are registered, derived from next-state count; they reflect an accepted operation one cycle after the edge where it happened.
- wr_accept = wr_en & (!wr_full | rd_accept); rd_accept = rd_en & !rd_empty.
- Simultaneous read+write: full -> both accepted, count stays DEPTH; empty -> write accepted only, read rejected (underflow set); otherwise both accepted, count unchanged.
- count_next = count + wr_accept - rd_accept; pointers are ADDR_WIDTH bits, wrap DEPTH-1 -> 0 naturally.
- Standard mode: on rd_accept, rd_data <= mem[rd_ptr] at that edge (1-cycle latency); otherwise rd_data holds its value.
- FWFT mode: rd_data = mem[rd_ptr] combinationally whenever rd_empty=0; rd_accept pops and advances to next word. First write into empty FIFO: rd_empty falls 1 cycle after the write edge, data valid at the same time. rd_data undefined (don't-care) while rd_empty=1.
- overflow <= 1 when wr_en & !wr_accept; underflow <= 1 when rd_en & !rd_accept; both held until err_clr=1 or rst. Set has priority over err_clr in the same cycle.
- Rejected operations change no pointer, count or data.

Decomposition:
- Package sync_fifo_pkg: MODE_STD=0, MODE_FWFT=1 constants; function for count width (ADDR_WIDTH+1).
- Sub-module sync_fifo_mem: register-array storage, one synchronous write port, one asynchronous read port (addr ADDR_WIDTH, data DATA_WIDTH). Top holds pointers, count, flags and the mode-dependent read register.

Test Plan:
(DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=6, AE_LEVEL=2)
1. Reset, write 0x11..0x88 (8 writes) -> count steps 1..8; rd_almost_empty low after count=3; wr_almost_full high at count=6; wr_full=1 after 8th; 9th write 0x99 -> overflow=1, count stays 8, no data lost.
2. From full, 8 reads (FWFT=0) -> rd_data 0x11..0x88 in order, each one cycle after rd_en; rd_empty=1 after 8th; extra read -> underflow=1, rd_data holds 0x88.
3. Full FIFO, wr_en=rd_en=1 with wr_data 0xA5 -> both accepted, count stays 8, 0xA5 read out last after draining 7 older words.
4. Empty FIFO, wr_en=rd_en=1 with 0x3C -> write only, underflow=1, count=1; then err_clr -> flags 0; read returns 0x3C.
5. FWFT=1: write 0x5A to empty -> rd_empty=0 and rd_data=0x5A next cycle without rd_en; write 0x6B, pop -> rd_data=0x6B immediately after pop edge.
6. Write 5 words, 3 reads interleaved, assert rst mid-stream -> next cycle count=0, rd_empty=1, flags at reset values; subsequent write/read returns only new data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo family.
//   MODE_STD / MODE_FWFT : values for the FWFT parameter of sync_fifo_prog
//   count_width()        : width of an occupancy counter able to hold 0..2**addr_width
package sync_fifo_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo_prog.
//   clk     : clock, write on rising edge
//   wr_en   : write strobe (already qualified by the FIFO control)
//   wr_addr : write address
//   wr_data : write word
//   rd_addr : asynchronous read address
//   rd_data : word at rd_addr (combinational)
// Contents are intentionally not reset.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// programmable almost-full / almost-empty flags, occupancy count and sticky
// overflow / underflow flags.
//   clk, rst         : clock and synchronous active-high reset
//   wr_en, wr_data   : write request and word
//   wr_full          : count == DEPTH
//   wr_almost_full   : count >= AF_LEVEL
//   rd_en, rd_data   : read request and word (registered in standard mode,
//                      combinational head-of-queue in FWFT mode)
//   rd_empty         : count == 0
//   rd_almost_empty  : count <= AE_LEVEL
//   count            : occupancy 0..DEPTH
//   overflow         : sticky, a write was rejected
//   underflow        : sticky, a read was rejected
//   err_clr          : clears overflow / underflow (a new error wins)
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FWFT       = MODE_STD,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;

  // A write into a full FIFO is fine when a read frees a slot on the same edge.
  always_comb begin
    rd_accept = rd_en & ~empty_q;
    wr_accept = wr_en & (~full_q | rd_accept);
    count_d   = count_q + CntW'(wr_accept) - CntW'(rd_accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= (AF_LEVEL == 0);
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_accept) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q     <= count_d;
      // Flags come from the next-state count so they line up with count.
      full_q      <= (count_d == CntW'(Depth));
      empty_q     <= (count_d == '0);
      af_q        <= (count_d >= CntW'(AF_LEVEL));
      ae_q        <= (count_d <= CntW'(AE_LEVEL));
      overflow_q  <= (wr_en & ~wr_accept) | (overflow_q & ~err_clr);
      underflow_q <= (rd_en & ~rd_accept) | (underflow_q & ~err_clr);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head of queue is always presented; meaningless while empty.
    assign rd_data = rd_word;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (rd_accept) begin
        rd_data_q <= rd_word;
      end
    end

    assign rd_data = rd_data_q;
  end

  assign wr_full         = full_q;
  assign wr_almost_full  = af_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = ae_q;
  assign count           = count_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Standard-mode instance
  logic       s_wr_en = 1'b0, s_rd_en = 1'b0, s_err_clr = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  logic [7:0] s_rd_data;
  logic       s_full, s_af, s_empty, s_ae, s_ov, s_un;
  logic [3:0] s_count;

  // FWFT instance
  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_err_clr = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic [7:0] f_rd_data;
  logic       f_full, f_af, f_empty, f_ae, f_ov, f_un;
  logic [3:0] f_count;

  sync_fifo_prog #(
    .DATA_WIDTH (8), .ADDR_WIDTH (3), .FWFT (0), .AF_LEVEL (6), .AE_LEVEL (2)
  ) dut_std (
    .clk (clk), .rst (rst),
    .wr_en (s_wr_en), .wr_data (s_wr_data), .wr_full (s_full), .wr_almost_full (s_af),
    .rd_en (s_rd_en), .rd_data (s_rd_data), .rd_empty (s_empty), .rd_almost_empty (s_ae),
    .count (s_count), .overflow (s_ov), .underflow (s_un), .err_clr (s_err_clr)
  );

  sync_fifo_prog #(
    .DATA_WIDTH (8), .ADDR_WIDTH (3), .FWFT (1), .AF_LEVEL (6), .AE_LEVEL (2)
  ) dut_fw (
    .clk (clk), .rst (rst),
    .wr_en (f_wr_en), .wr_data (f_wr_data), .wr_full (f_full), .wr_almost_full (f_af),
    .rd_en (f_rd_en), .rd_data (f_rd_data), .rd_empty (f_empty), .rd_almost_empty (f_ae),
    .count (f_count), .overflow (f_ov), .underflow (f_un), .err_clr (f_err_clr)
  );

  // One clock on the standard instance; outputs are stable on return.
  task automatic s_op(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    s_wr_en = we; s_wr_data = wd; s_rd_en = re; s_err_clr = clr;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_err_clr = 1'b0;
  endtask

  task automatic f_op(input logic we, input logic [7:0] wd, input logic re);
    f_wr_en = we; f_wr_data = wd; f_rd_en = re;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  task automatic s_reset_pulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (s_count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", s_count); end
    n_cmp++; if (s_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b exp=1", s_empty); end
    n_cmp++; if (s_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", s_full); end
    n_cmp++; if (s_af !== 1'b0) begin n_bad++; $display("FAIL reset_af got=%b exp=0", s_af); end
    n_cmp++; if (s_ae !== 1'b1) begin n_bad++; $display("FAIL reset_ae got=%b exp=1", s_ae); end
    n_cmp++; if ({s_ov, s_un} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b exp=00", {s_ov, s_un}); end
    n_cmp++; if (s_rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data got=%h exp=00", s_rd_data); end
    n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL reset_fw_empty got=%b exp=1", f_empty); end
    rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    logic [3:0] c;
    for (int i = 0; i < 8; i++) begin
      s_op(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
      c = 4'(i + 1);
      n_cmp++; if (s_count !== c) begin n_bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, c); end
      n_cmp++; if (s_ae !== (c <= 2)) begin n_bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, s_ae, (c <= 2)); end
      n_cmp++; if (s_af !== (c >= 6)) begin n_bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, s_af, (c >= 6)); end
      n_cmp++; if (s_full !== (c == 8)) begin n_bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, s_full, (c == 8)); end
      n_cmp++; if (s_empty !== 1'b0) begin n_bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, s_empty); end
    end
    s_op(1'b1, 8'h99, 1'b0, 1'b0);
    n_cmp++; if (s_ov !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", s_ov); end
    n_cmp++; if (s_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count got=%0d exp=8", s_count); end
    n_cmp++; if (s_un !== 1'b0) begin n_bad++; $display("FAIL ovf_un got=%b exp=0", s_un); end
  endtask

  task automatic test_drain_underflow();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      s_op(1'b0, 8'h00, 1'b1, 1'b0);
      e = 8'((i + 1) * 17);
      n_cmp++; if (s_rd_data !== e) begin n_bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, s_rd_data, e); end
      n_cmp++; if (s_count !== 4'(7 - i)) begin n_bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, s_count, 7 - i); end
      n_cmp++; if (s_empty !== (i == 7)) begin n_bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, s_empty, (i == 7)); end
    end
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (s_un !== 1'b1) begin n_bad++; $display("FAIL udf_flag got=%b exp=1", s_un); end
    n_cmp++; if (s_rd_data !== 8'h88) begin n_bad++; $display("FAIL udf_hold got=%h exp=88", s_rd_data); end
    n_cmp++; if (s_count !== 4'd0) begin n_bad++; $display("FAIL udf_count got=%0d exp=0", s_count); end
    s_op(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if ({s_ov, s_un} !== 2'b00) begin n_bad++; $display("FAIL clr_err got=%b exp=00", {s_ov, s_un}); end
  endtask

  task automatic test_full_rw();
    logic [7:0] e;
    s_reset_pulse();
    for (int i = 0; i < 8; i++) s_op(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
    s_op(1'b1, 8'hA5, 1'b1, 1'b0);
    n_cmp++; if (s_rd_data !== 8'h11) begin n_bad++; $display("FAIL fullrw_data got=%h exp=11", s_rd_data); end
    n_cmp++; if (s_count !== 4'd8) begin n_bad++; $display("FAIL fullrw_count got=%0d exp=8", s_count); end
    n_cmp++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL fullrw_ov got=%b exp=0", s_ov); end
    for (int i = 0; i < 8; i++) begin
      s_op(1'b0, 8'h00, 1'b1, 1'b0);
      e = (i == 7) ? 8'hA5 : 8'((i + 2) * 17);
      n_cmp++; if (s_rd_data !== e) begin n_bad++; $display("FAIL fullrw_drain[%0d] got=%h exp=%h", i, s_rd_data, e); end
    end
    n_cmp++; if (s_empty !== 1'b1) begin n_bad++; $display("FAIL fullrw_empty got=%b exp=1", s_empty); end
  endtask

  task automatic test_empty_rw();
    s_op(1'b1, 8'h3C, 1'b1, 1'b0);
    n_cmp++; if (s_count !== 4'd1) begin n_bad++; $display("FAIL emptyrw_count got=%0d exp=1", s_count); end
    n_cmp++; if (s_un !== 1'b1) begin n_bad++; $display("FAIL emptyrw_un got=%b exp=1", s_un); end
    n_cmp++; if (s_rd_data !== 8'hA5) begin n_bad++; $display("FAIL emptyrw_hold got=%h exp=a5", s_rd_data); end
    s_op(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if ({s_ov, s_un} !== 2'b00) begin n_bad++; $display("FAIL emptyrw_clr got=%b exp=00", {s_ov, s_un}); end
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (s_rd_data !== 8'h3C) begin n_bad++; $display("FAIL emptyrw_data got=%h exp=3c", s_rd_data); end
    n_cmp++; if (s_empty !== 1'b1) begin n_bad++; $display("FAIL emptyrw_empty got=%b exp=1", s_empty); end
    // A new error in the same cycle as err_clr must win.
    s_op(1'b0, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (s_un !== 1'b1) begin n_bad++; $display("FAIL set_over_clr got=%b exp=1", s_un); end
    s_op(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    f_op(1'b1, 8'h5A, 1'b0);
    n_cmp++; if (f_empty !== 1'b0) begin n_bad++; $display("FAIL fwft_empty got=%b exp=0", f_empty); end
    n_cmp++; if (f_rd_data !== 8'h5A) begin n_bad++; $display("FAIL fwft_first got=%h exp=5a", f_rd_data); end
    f_op(1'b1, 8'h6B, 1'b0);
    n_cmp++; if (f_rd_data !== 8'h5A) begin n_bad++; $display("FAIL fwft_head got=%h exp=5a", f_rd_data); end
    n_cmp++; if (f_count !== 4'd2) begin n_bad++; $display("FAIL fwft_count got=%0d exp=2", f_count); end
    f_op(1'b0, 8'h00, 1'b1);
    n_cmp++; if (f_rd_data !== 8'h6B) begin n_bad++; $display("FAIL fwft_pop got=%h exp=6b", f_rd_data); end
    f_op(1'b0, 8'h00, 1'b1);
    n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL fwft_drained got=%b exp=1", f_empty); end
    n_cmp++; if (f_un !== 1'b0) begin n_bad++; $display("FAIL fwft_un got=%b exp=0", f_un); end
  endtask

  task automatic test_reset_mid();
    s_op(1'b1, 8'h01, 1'b0, 1'b0);
    s_op(1'b1, 8'h02, 1'b0, 1'b0);
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    s_op(1'b1, 8'h03, 1'b0, 1'b0);
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    s_op(1'b1, 8'h04, 1'b0, 1'b0);
    s_op(1'b1, 8'h05, 1'b0, 1'b0);
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (s_rd_data !== 8'h03) begin n_bad++; $display("FAIL mid_data got=%h exp=03", s_rd_data); end
    n_cmp++; if (s_count !== 4'd2) begin n_bad++; $display("FAIL mid_count got=%0d exp=2", s_count); end
    // Reset wins over concurrent write/read.
    rst = 1'b1;
    s_op(1'b1, 8'hEE, 1'b1, 1'b0);
    rst = 1'b0;
    n_cmp++; if (s_count !== 4'd0) begin n_bad++; $display("FAIL rstmid_count got=%0d exp=0", s_count); end
    n_cmp++; if (s_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_empty got=%b exp=1", s_empty); end
    n_cmp++; if ({s_full, s_af, s_ae} !== 3'b001) begin n_bad++; $display("FAIL rstmid_flags got=%b exp=001", {s_full, s_af, s_ae}); end
    n_cmp++; if ({s_ov, s_un} !== 2'b00) begin n_bad++; $display("FAIL rstmid_err got=%b exp=00", {s_ov, s_un}); end
    n_cmp++; if (s_rd_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_rd_data got=%h exp=00", s_rd_data); end
    s_op(1'b1, 8'h77, 1'b0, 1'b0);
    n_cmp++; if (s_count !== 4'd1) begin n_bad++; $display("FAIL post_count got=%0d exp=1", s_count); end
    s_op(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (s_rd_data !== 8'h77) begin n_bad++; $display("FAIL post_data got=%h exp=77", s_rd_data); end
    n_cmp++; if (s_empty !== 1'b1) begin n_bad++; $display("FAIL post_empty got=%b exp=1", s_empty); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
